// File: rtl/sram_1p_march_bist.sv
// Behavioural single-port SRAM with bit-masked writes, a registered read port
// and a built-in March C- self-test engine sharing the array clock.
module sram_1p_march_bist #(
  parameter int P_DATA_WIDTH = 64,
  parameter int P_ADDR_WIDTH = 6
) (
  input  logic                    A_CLK,
  input  logic                    A_RST_N,
  input  logic                    A_MEN,
  input  logic                    A_WEN,
  input  logic                    A_REN,
  input  logic [P_ADDR_WIDTH-1:0] A_ADDR,
  input  logic [P_DATA_WIDTH-1:0] A_DIN,
  input  logic [P_DATA_WIDTH-1:0] A_BM,
  output logic [P_DATA_WIDTH-1:0] A_DOUT,
  input  logic                    A_BIST_START,
  output logic                    A_BIST_BUSY,
  output logic                    A_BIST_DONE,
  output logic                    A_BIST_FAIL,
  output logic [P_ADDR_WIDTH-1:0] A_BIST_FAIL_ADDR
);

  localparam int N = 2**P_ADDR_WIDTH;
  localparam logic [P_ADDR_WIDTH-1:0] ADDR_MAX = '1;
  localparam logic [P_DATA_WIDTH-1:0] ONES     = '1;
  localparam logic [P_DATA_WIDTH-1:0] ZEROS    = '0;

  typedef enum logic [3:0] {
    S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_CHK, S_DONE
  } state_t;

  // Packed so individual cells can be overridden from a bench
  logic [N-1:0][P_DATA_WIDTH-1:0] mem_q;

  state_t                  state_q, state_d;
  logic [P_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                    phase_q, phase_d;
  logic                    done_q, done_d;
  logic                    fail_q, fail_d;
  logic [P_ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [P_DATA_WIDTH-1:0] dout_q;

  logic                    chk_vld_q;
  logic [P_DATA_WIDTH-1:0] chk_data_q, chk_exp_q;
  logic [P_ADDR_WIDTH-1:0] chk_addr_q;

  logic                    busy;
  logic                    desc;
  logic                    bist_we, bist_re;
  logic [P_DATA_WIDTH-1:0] bist_wdata, bist_exp;
  logic                    func_we, func_re;
  logic                    mem_we;
  logic [P_ADDR_WIDTH-1:0] mem_waddr;
  logic [P_DATA_WIDTH-1:0] mem_wdata, mem_wmask;

  assign busy    = (state_q != S_IDLE) && (state_q != S_DONE);
  assign func_we = A_MEN & A_WEN & ~busy;
  assign func_re = A_MEN & A_REN & ~busy;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    phase_d     = phase_q;
    done_d      = done_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    desc        = 1'b0;
    bist_we     = 1'b0;
    bist_re     = 1'b0;
    bist_wdata  = ZEROS;
    bist_exp    = ZEROS;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (A_BIST_START) begin
          state_d     = S_M0;
          addr_d      = '0;
          phase_d     = 1'b0;
          done_d      = 1'b0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
        end
      end
      S_M0: begin
        bist_we = 1'b1;
        addr_d  = addr_q + 1'b1;
        if (addr_q == ADDR_MAX) state_d = S_M1;
      end
      S_M1, S_M2, S_M3, S_M4: begin
        desc = (state_q == S_M3) || (state_q == S_M4);
        if (!phase_q) begin
          bist_re  = 1'b1;
          bist_exp = ((state_q == S_M2) || (state_q == S_M4)) ? ONES : ZEROS;
          phase_d  = 1'b1;
        end else begin
          bist_we    = 1'b1;
          bist_wdata = ((state_q == S_M1) || (state_q == S_M3)) ? ONES : ZEROS;
          phase_d    = 1'b0;
          addr_d     = desc ? addr_q - 1'b1 : addr_q + 1'b1;
          if (addr_q == (desc ? '0 : ADDR_MAX)) begin
            // Element boundary: counter lands on the next element's start address
            case (state_q)
              S_M1:    state_d = S_M2;
              S_M2:    begin state_d = S_M3; addr_d = ADDR_MAX; end
              S_M3:    state_d = S_M4;
              default: begin state_d = S_M5; addr_d = '0; end
            endcase
          end
        end
      end
      S_M5: begin
        bist_re = 1'b1;
        addr_d  = addr_q + 1'b1;
        if (addr_q == ADDR_MAX) state_d = S_CHK;
      end
      S_CHK: begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (chk_vld_q && (chk_data_q != chk_exp_q) && !fail_q) begin
      fail_d      = 1'b1;
      fail_addr_d = chk_addr_q;
    end
  end

  always_ff @(posedge A_CLK or negedge A_RST_N) begin
    if (!A_RST_N) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      phase_q     <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      dout_q      <= '0;
      chk_vld_q   <= 1'b0;
      chk_data_q  <= '0;
      chk_exp_q   <= '0;
      chk_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      phase_q     <= phase_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      chk_vld_q   <= bist_re;
      if (bist_re) begin
        chk_data_q <= mem_q[addr_q];
        chk_exp_q  <= bist_exp;
        chk_addr_q <= addr_q;
      end
      if (func_re) dout_q <= mem_q[A_ADDR];
    end
  end

  // Array is never reset; writes are also blocked while reset is held
  assign mem_we    = A_RST_N & (bist_we | func_we);
  assign mem_waddr = bist_we ? addr_q     : A_ADDR;
  assign mem_wdata = bist_we ? bist_wdata : A_DIN;
  assign mem_wmask = bist_we ? ONES       : A_BM;

  always_ff @(posedge A_CLK) begin
    if (mem_we)
      mem_q[mem_waddr] <= (mem_q[mem_waddr] & ~mem_wmask) | (mem_wdata & mem_wmask);
  end

  assign A_DOUT           = dout_q;
  assign A_BIST_BUSY      = busy;
  assign A_BIST_DONE      = done_q;
  assign A_BIST_FAIL      = fail_q;
  assign A_BIST_FAIL_ADDR = fail_addr_q;

endmodule

// File: tb/tb_sram_1p_march_bist.sv
// Self-checking bench for sram_1p_march_bist: functional traffic against a
// word model with a read scoreboard, then clean, faulty and reset-aborted BIST runs.
module tb_sram_1p_march_bist;

  logic        A_CLK;
  logic        A_RST_N;
  logic        A_MEN, A_WEN, A_REN;
  logic [5:0]  A_ADDR;
  logic [63:0] A_DIN, A_BM, A_DOUT;
  logic        A_BIST_START, A_BIST_BUSY, A_BIST_DONE, A_BIST_FAIL;
  logic [5:0]  A_BIST_FAIL_ADDR;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] model [64];
  logic [63:0] sb_q [$];
  logic [63:0] last_dout;
  int          busy_cnt, first_fail;

  sram_1p_march_bist #(.P_DATA_WIDTH(64), .P_ADDR_WIDTH(6)) dut (
    .A_CLK(A_CLK), .A_RST_N(A_RST_N), .A_MEN(A_MEN), .A_WEN(A_WEN), .A_REN(A_REN),
    .A_ADDR(A_ADDR), .A_DIN(A_DIN), .A_BM(A_BM), .A_DOUT(A_DOUT),
    .A_BIST_START(A_BIST_START), .A_BIST_BUSY(A_BIST_BUSY), .A_BIST_DONE(A_BIST_DONE),
    .A_BIST_FAIL(A_BIST_FAIL), .A_BIST_FAIL_ADDR(A_BIST_FAIL_ADDR)
  );

  initial begin
    A_CLK = 1'b0;
    forever #5 A_CLK = ~A_CLK;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic access(input string tag, input logic we, input logic re,
                        input logic [5:0] a, input logic [63:0] d, input logic [63:0] m);
    logic [63:0] exp;
    A_MEN = 1'b1; A_WEN = we; A_REN = re; A_ADDR = a; A_DIN = d; A_BM = m;
    if (re) sb_q.push_back(model[a]);
    if (we) model[a] = (model[a] & ~m) | (d & m);
    @(posedge A_CLK); #1;
    A_MEN = 1'b0; A_WEN = 1'b0; A_REN = 1'b0;
    if (re) begin
      if (sb_q.size() == 0) begin
        check({tag, "_sb_empty"}, 64'd1, 64'd0);
      end else begin
        exp = sb_q.pop_front();
        check(tag, A_DOUT, exp);
        last_dout = exp;
      end
    end
  endtask

  // Pulses START, then follows BUSY; optional extra START, dropped functional
  // traffic and an asynchronous reset at a given busy cycle.
  task automatic run_bist(input logic extra_start, input logic inject, input int reset_at,
                          output int cnt, output int ffail);
    A_BIST_START = 1'b1;
    @(posedge A_CLK); #1;
    A_BIST_START = 1'b0;
    cnt   = 1;
    ffail = 0;
    check("bist_busy_rise", {63'd0, A_BIST_BUSY}, 64'd1);
    check("bist_fail_cleared", {63'd0, A_BIST_FAIL}, 64'd0);
    forever begin
      A_BIST_START = extra_start && (cnt == 10);
      if (inject && cnt == 20) begin
        A_MEN = 1'b1; A_WEN = 1'b1; A_ADDR = 6'd9; A_DIN = '1; A_BM = '1;
      end
      if (inject && cnt == 30) begin
        A_MEN = 1'b1; A_REN = 1'b1; A_ADDR = 6'd5;
      end
      @(posedge A_CLK); #1;
      A_BIST_START = 1'b0; A_MEN = 1'b0; A_WEN = 1'b0; A_REN = 1'b0;
      if (!A_BIST_BUSY) break;
      cnt++;
      if (A_BIST_FAIL && ffail == 0) ffail = cnt;
      if (cnt == reset_at) begin
        A_RST_N = 1'b0;
        #1;
        break;
      end
      if (cnt >= 2000) begin
        check("bist_timeout", 64'd1, 64'd0);
        break;
      end
    end
  endtask

  initial begin
    A_RST_N = 1'b0; A_MEN = 1'b0; A_WEN = 1'b0; A_REN = 1'b0;
    A_ADDR = '0; A_DIN = '0; A_BM = '0; A_BIST_START = 1'b0;
    last_dout = '0;
    repeat (3) @(posedge A_CLK);
    #1;
    check("rst_dout", A_DOUT, 64'd0);
    check("rst_busy", {63'd0, A_BIST_BUSY}, 64'd0);
    check("rst_done", {63'd0, A_BIST_DONE}, 64'd0);
    check("rst_fail", {63'd0, A_BIST_FAIL}, 64'd0);
    check("rst_fail_addr", {58'd0, A_BIST_FAIL_ADDR}, 64'd0);
    A_RST_N = 1'b1;
    @(posedge A_CLK); #1;

    access("wr5", 1'b1, 1'b0, 6'd5, 64'h0123456789ABCDEF, '1);
    access("rd5", 1'b0, 1'b1, 6'd5, '0, '0);
    check("rd5_const", A_DOUT, 64'h0123456789ABCDEF);
    for (int i = 0; i < 3; i++) begin
      @(posedge A_CLK); #1;
      check("dout_hold", A_DOUT, last_dout);
    end

    access("wr5_bm", 1'b1, 1'b0, 6'd5, 64'd0, 64'h00000000FFFFFFFF);
    access("rd5_bm", 1'b0, 1'b1, 6'd5, '0, '0);
    check("rd5_bm_const", A_DOUT, 64'h0123456700000000);

    access("wr9", 1'b1, 1'b0, 6'd9, {8{8'hAA}}, '1);
    access("rw9", 1'b1, 1'b1, 6'd9, {8{8'h55}}, '1);
    check("rw9_const", A_DOUT, {8{8'hAA}});
    access("rd9", 1'b0, 1'b1, 6'd9, '0, '0);
    check("rd9_const", A_DOUT, {8{8'h55}});
    access("men0", 1'b0, 1'b0, 6'd9, '0, '0);
    A_MEN = 1'b0; A_WEN = 1'b1; A_REN = 1'b1; A_ADDR = 6'd5; A_DIN = '1; A_BM = '1;
    @(posedge A_CLK); #1;
    A_WEN = 1'b0; A_REN = 1'b0;
    check("men0_no_read", A_DOUT, last_dout);
    access("rd5_men0", 1'b0, 1'b1, 6'd5, '0, '0);

    // Clean run with a redundant START and dropped functional traffic
    run_bist(1'b1, 1'b1, 0, busy_cnt, first_fail);
    check("clean_busy_cycles", 64'(busy_cnt), 64'd641);
    check("clean_done", {63'd0, A_BIST_DONE}, 64'd1);
    check("clean_fail", {63'd0, A_BIST_FAIL}, 64'd0);
    check("clean_fail_addr", {58'd0, A_BIST_FAIL_ADDR}, 64'd0);
    check("dout_held_bist", A_DOUT, last_dout);
    for (int i = 0; i < 64; i++) model[i] = '0;
    access("rd9_after_bist", 1'b0, 1'b1, 6'd9, '0, '0);
    access("rd5_after_bist", 1'b0, 1'b1, 6'd5, '0, '0);
    access("rd63_after_bist", 1'b0, 1'b1, 6'd63, '0, '0);

    force dut.mem_q[37][12] = 1'b0;
    run_bist(1'b0, 1'b0, 0, busy_cnt, first_fail);
    check("fault_busy_cycles", 64'(busy_cnt), 64'd641);
    check("fault_done", {63'd0, A_BIST_DONE}, 64'd1);
    check("fault_fail", {63'd0, A_BIST_FAIL}, 64'd1);
    check("fault_fail_addr", {58'd0, A_BIST_FAIL_ADDR}, 64'd37);
    // M2 spans busy cycles 193..320; the flag lags the read by two cycles
    check("fault_in_m2", {63'd0, (first_fail >= 193 && first_fail <= 322)}, 64'd1);

    // Restart clears FAIL, then reset aborts the run after FAIL has re-risen
    run_bist(1'b0, 1'b0, 300, busy_cnt, first_fail);
    check("abort_fail_seen", {63'd0, (first_fail > 0)}, 64'd1);
    check("abort_busy", {63'd0, A_BIST_BUSY}, 64'd0);
    check("abort_done", {63'd0, A_BIST_DONE}, 64'd0);
    check("abort_fail", {63'd0, A_BIST_FAIL}, 64'd0);
    check("abort_fail_addr", {58'd0, A_BIST_FAIL_ADDR}, 64'd0);
    check("abort_dout", A_DOUT, 64'd0);
    @(posedge A_CLK); #1;
    A_RST_N = 1'b1;
    @(posedge A_CLK); #1;
    check("abort_idle", {63'd0, A_BIST_BUSY}, 64'd0);

    run_bist(1'b0, 1'b0, 0, busy_cnt, first_fail);
    check("rerun_busy_cycles", 64'(busy_cnt), 64'd641);
    check("rerun_done", {63'd0, A_BIST_DONE}, 64'd1);
    check("rerun_fail", {63'd0, A_BIST_FAIL}, 64'd1);
    check("rerun_fail_addr", {58'd0, A_BIST_FAIL_ADDR}, 64'd37);
    release dut.mem_q[37][12];

    repeat (2) @(posedge A_CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
